// File: rtl/minterm_sweep_if.sv
// Handshake/result bundle for the minterm sweep checker.
// The bench drives it through master; the checker sits on slave.
interface minterm_sweep_if #(parameter int N = 4);
   logic              load_a;
   logic              load_b;
   logic [2**N-1:0]   tt_in;
   logic              start;
   logic              busy;
   logic              done;
   logic              vec_valid;
   logic [N-1:0]      vec;
   logic              sa;
   logic              sb;
   logic [N:0]        mism_count;
   logic [N-1:0]      first_mism;
   logic              any_mism;

   modport master (
      output load_a, load_b, tt_in, start,
      input  busy, done, vec_valid, vec, sa, sb, mism_count, first_mism, any_mism
   );

   modport slave (
      input  load_a, load_b, tt_in, start,
      output busy, done, vec_valid, vec, sa, sb, mism_count, first_mism, any_mism
   );
endinterface

// File: rtl/minterm_sweep_checker.sv
// Exhaustive equivalence sweep of two N-input truth tables, one minterm per clock,
// reporting mismatch count and the lowest mismatching minterm.
module minterm_sweep_checker #(
   parameter int N = 4
) (
   input  logic          clk,
   input  logic          reset,
   minterm_sweep_if.slave bus
);
   localparam logic [N-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t           state, state_nxt;
   logic [2**N-1:0]  tab_a, tab_b;
   logic [N-1:0]     vec;
   logic [N:0]       mism_count;
   logic [N-1:0]     first_mism;
   logic             any_mism;
   logic             sweeping;
   logic             start_acc;
   logic             sa, sb;

   assign sweeping  = (state == SWEEP);
   assign start_acc = bus.start && !sweeping;
   assign sa        = tab_a[vec];
   assign sb        = tab_b[vec];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SWEEP;
         SWEEP:   if (vec == LAST) state_nxt = DONE;
         DONE:    if (bus.start) state_nxt = SWEEP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tab_a      <= '0;
         tab_b      <= '0;
         vec        <= '0;
         mism_count <= '0;
         first_mism <= '0;
         any_mism   <= 1'b0;
      end else begin
         // Tables are frozen during a sweep; a load alongside start lands before the first vector.
         if (!sweeping) begin
            if (bus.load_a) tab_a <= bus.tt_in;
            if (bus.load_b) tab_b <= bus.tt_in;
         end
         if (start_acc) begin
            vec        <= '0;
            mism_count <= '0;
            first_mism <= '0;
            any_mism   <= 1'b0;
         end else if (sweeping) begin
            if (sa != sb) begin
               mism_count <= mism_count + {{N{1'b0}}, 1'b1};
               if (!any_mism) begin
                  first_mism <= vec;
                  any_mism   <= 1'b1;
               end
            end
            if (vec != LAST) vec <= vec + {{(N-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.busy       = sweeping;
   assign bus.done       = (state == DONE);
   assign bus.vec_valid  = sweeping;
   assign bus.vec        = vec;
   assign bus.sa         = sa;
   assign bus.sb         = sb;
   assign bus.mism_count = mism_count;
   assign bus.first_mism = first_mism;
   assign bus.any_mism   = any_mism;
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker at N=4 with A = 16'h0E26.
module tb_minterm_sweep_checker;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   pass  = 0;

   minterm_sweep_if #(.N(N)) bus ();

   minterm_sweep_checker #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic load(input bit a, input bit b, input logic [15:0] val);
      @(negedge clk);
      bus.load_a = a;
      bus.load_b = b;
      bus.tt_in  = val;
      @(negedge clk);
      bus.load_a = 1'b0;
      bus.load_b = 1'b0;
   endtask

   // Leaves the bench at the negedge right after the accepting edge.
   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy) cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else pass++;
      total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else pass++;
      total++; if (bus.vec_valid !== 1'b0) $display("FAIL reset_vec_valid got %0b want 0", bus.vec_valid); else pass++;
      total++; if (bus.vec !== 4'd0) $display("FAIL reset_vec got %0d want 0", bus.vec); else pass++;
      total++; if (bus.mism_count !== 5'd0) $display("FAIL reset_mism_count got %0d want 0", bus.mism_count); else pass++;
      total++; if (bus.first_mism !== 4'd0) $display("FAIL reset_first_mism got %0d want 0", bus.first_mism); else pass++;
      total++; if (bus.any_mism !== 1'b0) $display("FAIL reset_any_mism got %0b want 0", bus.any_mism); else pass++;
      total++; if ({bus.sa, bus.sb} !== 2'b00) $display("FAIL reset_sa_sb got %0b want 00", {bus.sa, bus.sb}); else pass++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL idle_hold got busy=%0b done=%0b want 0 0", bus.busy, bus.done); else pass++;
   endtask

   task automatic test_equal();
      int cyc; bit ok;
      load(1'b1, 1'b1, 16'h0E26);
      pulse_start();
      wait_done(cyc, ok);
      total++; if (!ok) $display("FAIL equal_timeout got no done want done"); else pass++;
      total++; if (cyc != 16) $display("FAIL equal_busy_cycles got %0d want 16", cyc); else pass++;
      total++; if (bus.mism_count !== 5'd0) $display("FAIL equal_mism_count got %0d want 0", bus.mism_count); else pass++;
      total++; if (bus.any_mism !== 1'b0) $display("FAIL equal_any_mism got %0b want 0", bus.any_mism); else pass++;
      total++; if (bus.first_mism !== 4'd0) $display("FAIL equal_first_mism got %0d want 0", bus.first_mism); else pass++;
      total++; if (bus.vec !== 4'd15) $display("FAIL equal_vec_hold got %0d want 15", bus.vec); else pass++;
   endtask

   task automatic test_single_drop();
      int cyc; bit ok;
      load(1'b0, 1'b1, 16'h0E24);
      pulse_start();
      wait_done(cyc, ok);
      total++; if (!ok) $display("FAIL drop_timeout got no done want done"); else pass++;
      total++; if (bus.mism_count !== 5'd1) $display("FAIL drop_mism_count got %0d want 1", bus.mism_count); else pass++;
      total++; if (bus.first_mism !== 4'd1) $display("FAIL drop_first_mism got %0d want 1", bus.first_mism); else pass++;
      total++; if (bus.any_mism !== 1'b1) $display("FAIL drop_any_mism got %0b want 1", bus.any_mism); else pass++;
   endtask

   task automatic test_complement();
      int cyc; bit ok;
      load(1'b0, 1'b1, 16'hF1D9);
      pulse_start();
      wait_done(cyc, ok);
      total++; if (!ok) $display("FAIL compl_timeout got no done want done"); else pass++;
      total++; if (bus.mism_count !== 5'b10000) $display("FAIL compl_mism_count got %0d want 16", bus.mism_count); else pass++;
      total++; if (bus.first_mism !== 4'd0) $display("FAIL compl_first_mism got %0d want 0", bus.first_mism); else pass++;
      total++; if (bus.any_mism !== 1'b1) $display("FAIL compl_any_mism got %0b want 1", bus.any_mism); else pass++;
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok;
      load(1'b0, 1'b1, 16'h0E22);
      total++; if (bus.done !== 1'b1) $display("FAIL b2b_done_held got %0b want 1", bus.done); else pass++;
      pulse_start();
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL b2b_restart got busy=%0b done=%0b want 1 0", bus.busy, bus.done); else pass++;
      total++; if (bus.mism_count !== 5'd0 || bus.any_mism !== 1'b0) $display("FAIL b2b_clear got count=%0d any=%0b want 0 0", bus.mism_count, bus.any_mism); else pass++;
      wait_done(cyc, ok);
      total++; if (!ok) $display("FAIL b2b_timeout got no done want done"); else pass++;
      total++; if (bus.mism_count !== 5'd1) $display("FAIL b2b_mism_count got %0d want 1", bus.mism_count); else pass++;
      total++; if (bus.first_mism !== 4'd2) $display("FAIL b2b_first_mism got %0d want 2", bus.first_mism); else pass++;
   endtask

   task automatic test_latency();
      load(1'b0, 1'b1, 16'h0E26);
      pulse_start();
      for (int k = 1; k <= 17; k++) begin
         if (k <= 16) begin
            total++;
            if (bus.busy !== 1'b1 || bus.vec_valid !== 1'b1 || bus.done !== 1'b0 || bus.vec !== 4'(k - 1))
               $display("FAIL lat_t+%0d got busy=%0b valid=%0b done=%0b vec=%0d want 1 1 0 %0d",
                        k, bus.busy, bus.vec_valid, bus.done, bus.vec, k - 1);
            else pass++;
         end else begin
            total++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0)
               $display("FAIL lat_done got done=%0b busy=%0b want 1 0", bus.done, bus.busy);
            else pass++;
         end
         if (k == 4) begin
            bus.start  = 1'b1;
            bus.load_b = 1'b1;
            bus.tt_in  = 16'h0000;
         end else if (k == 5) begin
            bus.start  = 1'b0;
            bus.load_b = 1'b0;
         end
         if (k < 17) @(negedge clk);
      end
      total++; if (bus.mism_count !== 5'd0) $display("FAIL lat_b_unchanged got %0d want 0", bus.mism_count); else pass++;
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok; bit seen; bit nz;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.vec == 4'd7 && bus.busy) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++; if (!seen) $display("FAIL mid_reach7 got no vec=7 want vec=7"); else pass++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_valid !== 1'b0 || bus.vec !== 4'd0 ||
          bus.mism_count !== 5'd0 || bus.first_mism !== 4'd0 || bus.any_mism !== 1'b0)
         $display("FAIL mid_reset_outputs got busy=%0b done=%0b valid=%0b vec=%0d cnt=%0d first=%0d any=%0b want all 0",
                  bus.busy, bus.done, bus.vec_valid, bus.vec, bus.mism_count, bus.first_mism, bus.any_mism);
      else pass++;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mid_idle got busy=%0b done=%0b want 0 0", bus.busy, bus.done); else pass++;
      pulse_start();
      nz = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (bus.sa !== 1'b0 || bus.sb !== 1'b0) nz = 1'b1;
         @(negedge clk);
      end
      total++; if (nz) $display("FAIL mid_tables_cleared got nonzero sa/sb want 0"); else pass++;
      wait_done(cyc, ok);
      total++; if (!ok) $display("FAIL mid_timeout got no done want done"); else pass++;
      total++; if (bus.mism_count !== 5'd0) $display("FAIL mid_mism_count got %0d want 0", bus.mism_count); else pass++;
   endtask

   initial begin
      bus.load_a = 1'b0;
      bus.load_b = 1'b0;
      bus.tt_in  = '0;
      bus.start  = 1'b0;
      test_reset();
      test_equal();
      test_single_drop();
      test_complement();
      test_back_to_back();
      test_latency();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
